// File: rtl/rope_pkg.sv
// Shared types and constants for the rope object mover.
// Positions are fixed point: 11 integer pixel bits over FRAC_BITS fraction bits.
package rope_pkg;
    localparam int FRAC_BITS   = 6;
    localparam int PIX_W       = 11;
    localparam int POS_W       = PIX_W + FRAC_BITS;
    localparam int X_MAX       = 608;
    localparam int GEN_LATENCY = 2;

    typedef logic [POS_W-1:0] pos_t;

    localparam pos_t X_MAX_RAW = pos_t'(X_MAX) << FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        REQUEST,
        WAIT_GEN,
        LATCH
    } state_t;
endpackage

// File: rtl/rope_pos_step.sv
// One-rope position step: advance by speed and detect edge wrap.
// dir_i=0 moves right from the left edge, dir_i=1 moves left from the right edge.
module rope_pos_step
    import rope_pkg::*;
(
    input  pos_t       pos_i,
    input  logic [6:0] speed_i,
    input  logic       dir_i,
    output pos_t       pos_o,
    output logic       wrap_o
);
    pos_t spd_ext;
    pos_t sum;

    assign spd_ext = pos_t'(speed_i);
    assign sum     = pos_i + spd_ext;

    always_comb begin
        pos_o  = pos_i;
        wrap_o = 1'b0;
        if (!dir_i) begin
            if (sum[POS_W-1:FRAC_BITS] > PIX_W'(X_MAX)) begin
                pos_o  = '0;
                wrap_o = 1'b1;
            end else begin
                pos_o = sum;
            end
        end else if (spd_ext > pos_i) begin
            // compare before subtracting so the position never underflows
            pos_o  = X_MAX_RAW;
            wrap_o = 1'b1;
        end else begin
            pos_o = pos_i - spd_ext;
        end
    end
endmodule

// File: rtl/rope_object_mover.sv
// Per-frame mover for objects on horizontal ropes, one shared step unit.
// Wrapped ropes request fresh speeds from an external generator.
module rope_object_mover #(
    parameter int LEFT_ROPES  = 3,
    parameter int RIGHT_ROPES = 3,
    parameter int ROPES       = LEFT_ROPES + RIGHT_ROPES,
    parameter int FRAC_BITS   = rope_pkg::FRAC_BITS,
    parameter int X_MAX       = rope_pkg::X_MAX,
    parameter int GEN_LATENCY = rope_pkg::GEN_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   enable,
    input  logic [ROPES-1:0][6:0]  X_SPEED,
    output logic                   speedTrigger,
    output logic [ROPES-1:0][10:0] X_POS,
    output logic [ROPES-1:0]       wrapEvent
);
    import rope_pkg::*;

    localparam int IW = (ROPES > 1) ? $clog2(ROPES) : 1;
    localparam logic [IW-1:0] LAST        = IW'(ROPES - 1);
    localparam logic [IW-1:0] FIRST_RIGHT = IW'(LEFT_ROPES);
    localparam logic [3:0]    WAIT_LAST   = 4'(GEN_LATENCY - 1);
    localparam pos_t          RIGHT_HOME  = pos_t'(X_MAX) << FRAC_BITS;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    pos_t             pos_q [ROPES];
    pos_t             pos_d [ROPES];
    logic [6:0]       spd_q [ROPES];
    logic [6:0]       spd_d [ROPES];
    logic [ROPES-1:0] pend_q, pend_d;
    logic [ROPES-1:0] wrap_q, wrap_d;
    logic             trig_q, trig_d;
    pos_t             step_pos;
    logic             step_wrap;

    rope_pos_step u_step (
        .pos_i   (pos_q[idx_q]),
        .speed_i (spd_q[idx_q]),
        .dir_i   (idx_q >= FIRST_RIGHT),
        .pos_o   (step_pos),
        .wrap_o  (step_wrap)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        spd_d   = spd_q;
        pend_d  = pend_q;
        wrap_d  = '0;
        trig_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startOfFrame && enable) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                pos_d[idx_q] = step_pos;
                if (step_wrap) begin
                    pend_d[idx_q] = 1'b1;
                    wrap_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST) begin
                    state_d = (|pend_d) ? REQUEST : IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            REQUEST: begin
                trig_d  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_GEN;
            end
            WAIT_GEN: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            LATCH: begin
                for (int i = 0; i < ROPES; i++) begin
                    if (pend_q[i]) spd_d[i] = X_SPEED[i];
                end
                pend_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQUEST;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < ROPES; i++) begin
                pos_q[i] <= (i < LEFT_ROPES) ? pos_t'(0) : RIGHT_HOME;
                spd_q[i] <= '0;
            end
            pend_q  <= '1;
            wrap_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            spd_q   <= spd_d;
            pend_q  <= pend_d;
            wrap_q  <= wrap_d;
            trig_q  <= trig_d;
        end
    end

    assign speedTrigger = trig_q;
    assign wrapEvent    = wrap_q;

    always_comb begin
        for (int i = 0; i < ROPES; i++) begin
            X_POS[i] = pos_q[i][FRAC_BITS +: 11];
        end
    end
endmodule

// File: tb/tb_rope_object_mover.sv
// Bench for rope_object_mover: frame-schedule reference model plus directed checks.
// Model tracks which clock edge each rope update, trigger and latch must land on.
module tb_rope_object_mover;
    localparam int NR = 6;
    localparam int LR = 3;
    localparam int XM = 608;
    localparam int GL = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                startOfFrame = 1'b0;
    logic                enable = 1'b1;
    logic [NR-1:0][6:0]  X_SPEED;
    logic                speedTrigger;
    logic [NR-1:0][10:0] X_POS;
    logic [NR-1:0]       wrapEvent;

    int total = 0;
    int bad = 0;
    int trig_cnt = 0;
    int wrap_cnt = 0;

    always #5 clk = ~clk;

    rope_object_mover dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .X_SPEED      (X_SPEED),
        .speedTrigger (speedTrigger),
        .X_POS        (X_POS),
        .wrapEvent    (wrapEvent)
    );

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d t=%0t", nm, idx, act, exp, $time);
        end
    endtask

    // Reference model: event schedule indexed by clock edge number.
    int now = 0;
    int trig_edge = -1;
    int latch_edge = -1;
    int free_edge = 0;
    int m_pos [NR];
    int m_spd [NR];
    int m_new [NR];
    int upd_edge [NR];
    bit m_nwrap [NR];
    bit m_pend [NR];
    bit m_valid = 1'b0;
    logic [NR-1:0] exp_wrap = '0;
    logic exp_trig = 1'b0;

    initial begin : model
        forever begin
            bit any;
            int p;
            @(posedge clk);
            now++;
            exp_wrap = '0;
            exp_trig = (now == trig_edge);
            if (reset) begin
                for (int i = 0; i < NR; i++) begin
                    m_pos[i] = (i < LR) ? 0 : XM * 64;
                    m_spd[i] = 0;
                    m_pend[i] = 1'b1;
                    upd_edge[i] = -1;
                end
                trig_edge = now + 1;
                latch_edge = now + 2 + GL;
                free_edge = now + 3 + GL;
                exp_trig = 1'b0;
                m_valid = 1'b1;
            end else begin
                for (int i = 0; i < NR; i++) begin
                    if (upd_edge[i] == now) begin
                        m_pos[i] = m_new[i];
                        exp_wrap[i] = m_nwrap[i];
                    end
                end
                if (now == latch_edge) begin
                    for (int i = 0; i < NR; i++) begin
                        if (m_pend[i]) m_spd[i] = int'(X_SPEED[i]);
                        m_pend[i] = 1'b0;
                    end
                end
                if (now >= free_edge && startOfFrame && enable) begin
                    any = 1'b0;
                    for (int i = 0; i < NR; i++) begin
                        if (i < LR) begin
                            p = m_pos[i] + m_spd[i];
                            m_nwrap[i] = (p / 64 > XM);
                            if (m_nwrap[i]) p = 0;
                        end else begin
                            m_nwrap[i] = (m_spd[i] > m_pos[i]);
                            p = m_nwrap[i] ? XM * 64 : m_pos[i] - m_spd[i];
                        end
                        m_new[i] = p;
                        upd_edge[i] = now + 1 + i;
                        if (m_nwrap[i]) begin
                            m_pend[i] = 1'b1;
                            any = 1'b1;
                        end
                    end
                    if (any) begin
                        trig_edge = now + NR + 1;
                        latch_edge = now + NR + 2 + GL;
                        free_edge = now + NR + 3 + GL;
                    end else begin
                        free_edge = now + NR + 1;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                for (int i = 0; i < NR; i++) begin
                    chk("xpos", i, 32'(X_POS[i]), m_pos[i] / 64);
                end
                chk("wrap", 0, 32'(wrapEvent), 32'(exp_wrap));
                chk("trig", 0, 32'(speedTrigger), 32'(exp_trig));
            end
            if (speedTrigger === 1'b1) trig_cnt++;
            wrap_cnt += $countones(wrapEvent);
        end
    end

    task automatic frame();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    initial begin : stim
        X_SPEED = {NR{7'd50}};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("lit_trig_clk1", 0, 32'(speedTrigger), 1);
        @(negedge clk);
        chk("lit_trig_clk2", 0, 32'(speedTrigger), 0);
        repeat (2) @(negedge clk);
        chk("lit_reset_x", 0, 32'(X_POS[0]), 0);
        chk("lit_reset_x", 3, 32'(X_POS[3]), 608);
        frame();
        chk("lit_spd50_x", 0, 32'(X_POS[0]), 0);
        chk("lit_spd50_x", 3, 32'(X_POS[3]), 607);

        // per-rope speeds {r5..r0}
        X_SPEED = {7'd0, 7'd127, 7'd64, 7'd0, 7'd32, 7'd64};
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        X_SPEED = {7'd5, 7'd0, 7'd5, 7'd5, 7'd5, 7'd5};
        trig_cnt = 0;
        wrap_cnt = 0;
        frames(10);
        chk("lit_10f_x", 0, 32'(X_POS[0]), 10);
        chk("lit_10f_x", 2, 32'(X_POS[2]), 0);
        chk("lit_10f_x", 3, 32'(X_POS[3]), 598);
        chk("lit_10f_x", 5, 32'(X_POS[5]), 608);
        chk("lit_10f_trigs", 0, trig_cnt, 0);
        chk("lit_10f_wraps", 0, wrap_cnt, 0);
        frames(297);
        chk("lit_307f_x", 4, 32'(X_POS[4]), 608);
        chk("lit_307f_trigs", 0, trig_cnt, 1);
        chk("lit_307f_wraps", 0, wrap_cnt, 1);
        frames(301);
        chk("lit_608f_x", 0, 32'(X_POS[0]), 608);
        chk("lit_608f_x", 1, 32'(X_POS[1]), 304);
        chk("lit_608f_x", 3, 32'(X_POS[3]), 0);

        // wrap frame with an extra startOfFrame dropped during WAIT_GEN
        X_SPEED = {7'd9, 7'd9, 7'd33, 7'd9, 7'd9, 7'd70};
        trig_cnt = 0;
        wrap_cnt = 0;
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (7) @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (8) @(negedge clk);
        chk("lit_wrap_x", 0, 32'(X_POS[0]), 0);
        chk("lit_wrap_x", 3, 32'(X_POS[3]), 608);
        chk("lit_wrap_trigs", 0, trig_cnt, 1);
        chk("lit_wrap_wraps", 0, wrap_cnt, 2);
        frame();
        chk("lit_reload_x", 0, 32'(X_POS[0]), 1);
        chk("lit_reload_x", 1, 32'(X_POS[1]), 305);
        chk("lit_reload_x", 3, 32'(X_POS[3]), 607);

        enable = 1'b0;
        frames(3);
        chk("lit_frozen_x", 0, 32'(X_POS[0]), 1);
        chk("lit_frozen_x", 3, 32'(X_POS[3]), 607);

        // enable dropped right after acceptance must not abort the sweep
        @(negedge clk);
        startOfFrame = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        enable = 1'b0;
        repeat (12) @(negedge clk);
        chk("lit_en_drop_x", 0, 32'(X_POS[0]), 2);
        chk("lit_en_drop_x", 3, 32'(X_POS[3]), 606);

        // reset sampled while rope 2 is being processed
        enable = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("lit_midrst_x", 0, 32'(X_POS[0]), 0);
        chk("lit_midrst_x", 3, 32'(X_POS[3]), 608);
        chk("lit_midrst_trig0", 0, 32'(speedTrigger), 0);
        @(negedge clk);
        chk("lit_midrst_trig1", 0, 32'(speedTrigger), 1);
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
